// File: rtl/fwd_ctrl_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
package fwd_ctrl_pkg;

  // Architectural register-address width (16 registers, R0 hardwired zero).
  localparam int REG_AW = 4;

  typedef logic [REG_AW-1:0] reg_t;

  // Per-operand forward select, bit order {f1, f2}.
  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  // Shadow copy of the instruction occupying EX.
  typedef struct packed {
    reg_t rs;
    reg_t rt;
    logic rs_used;
    logic rt_used;
    reg_t rd;
    logic we;
    logic load;
  } idex_t;

  // Shadow copy of the instruction occupying MEM.
  typedef struct packed {
    reg_t rd;
    logic we;
    logic load;
  } exmem_t;

  // Shadow copy of the instruction occupying WB.
  typedef struct packed {
    reg_t rd;
    logic we;
  } memwb_t;

  // A bubble reads nothing and writes nothing.
  localparam idex_t  IDEX_BUBBLE  = '0;
  localparam exmem_t EXMEM_BUBBLE = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;

  // The newest producer (EX/MEM) wins over the older one (MEM/WB).
  function automatic fwd_sel_e fwd_encode(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit)      return FWD_EXMEM;
    else if (memwb_hit) return FWD_MEMWB;
    else                return FWD_NONE;
  endfunction

endpackage

// File: rtl/fwd_ctrl_if.sv
// ID-stage instruction fields in, forward selects and stall out.
//
// Handshake: there is no valid/ready pair. The pipeline (master) presents the
// ID fields and flush every cycle; the hazard unit (slave) answers in the same
// cycle with combinational fa*/fb*/stall. A bubble in ID is expressed by
// id_we=0, id_load=0, id_rs_used=0, id_rt_used=0.
interface fwd_ctrl_if #(parameter int REG_AW = fwd_ctrl_pkg::REG_AW);

  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_we;
  logic              id_load;
  logic              flush;
  logic              fa1;
  logic              fa2;
  logic              fb1;
  logic              fb2;
  logic              stall;

  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_we, id_load, flush,
    input  fa1, fa2, fb1, fb2, stall
  );

  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_we, id_load, flush,
    output fa1, fa2, fb1, fb2, stall
  );

endinterface

// File: rtl/fwd_match.sv
// Compares one source operand of the EX instruction against the MEM and WB
// producers and returns the forward select {f1, f2}.
module fwd_match #(
  parameter int REG_AW = fwd_ctrl_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_we,
  input  logic              exmem_load,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_we,
  output logic [1:0]        sel
);
  import fwd_ctrl_pkg::*;

  logic     exmem_hit;
  logic     memwb_hit;
  fwd_sel_e sel_e;

  // Match each producer; a load in MEM has no value yet so it never hits
  // there, and R0 is never a real destination.
  always_comb begin
    exmem_hit = src_used && exmem_we && !exmem_load &&
                (exmem_rd == src) && (exmem_rd != '0);
    memwb_hit = src_used && memwb_we &&
                (memwb_rd == src) && (memwb_rd != '0);
    sel_e     = fwd_encode(exmem_hit, memwb_hit);
  end

  assign sel = sel_e;

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard unit for a 5-stage pipeline. Keeps a shadow
// copy of the register fields of the EX, MEM and WB instructions and derives
// operand forward selects and the load-use stall from them.
// Shadow-stage field widths come from the package; REG_AW must match it.
module fwd_ctrl #(
  parameter int REG_AW = fwd_ctrl_pkg::REG_AW
) (
  input  logic           clk,
  input  logic           rst,
  fwd_ctrl_if.slave      bus
);
  import fwd_ctrl_pkg::*;

  idex_t      idex_q;
  exmem_t     exmem_q;
  memwb_t     memwb_q;
  idex_t      id_pkt;
  logic       rs_dep;
  logic       rt_dep;
  logic       stall_w;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  // Pack the ID-stage fields into the shape of the EX shadow stage.
  always_comb begin
    id_pkt         = IDEX_BUBBLE;
    id_pkt.rs      = bus.id_rs;
    id_pkt.rt      = bus.id_rt;
    id_pkt.rs_used = bus.id_rs_used;
    id_pkt.rt_used = bus.id_rt_used;
    id_pkt.rd      = bus.id_rd;
    id_pkt.we      = bus.id_we;
    id_pkt.load    = bus.id_load;
  end

  // Load-use: the load now in EX writes a register the ID instruction reads.
  // The bubble it causes clears idex_q.load, so this lasts one cycle.
  always_comb begin
    rs_dep  = bus.id_rs_used && (bus.id_rs == idex_q.rd);
    rt_dep  = bus.id_rt_used && (bus.id_rt == idex_q.rd);
    stall_w = idex_q.load && idex_q.we && (idex_q.rd != '0) && (rs_dep || rt_dep);
  end

  // Advance the shadow pipeline; a stalled or flushed ID instruction becomes
  // a bubble in EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= IDEX_BUBBLE;
      exmem_q <= EXMEM_BUBBLE;
      memwb_q <= MEMWB_BUBBLE;
    end else begin
      memwb_q.rd   <= exmem_q.rd;
      memwb_q.we   <= exmem_q.we;
      exmem_q.rd   <= idex_q.rd;
      exmem_q.we   <= idex_q.we;
      exmem_q.load <= idex_q.load;
      if (stall_w || bus.flush) begin
        idex_q <= IDEX_BUBBLE;
      end else begin
        idex_q <= id_pkt;
      end
    end
  end

  fwd_match #(.REG_AW(REG_AW)) u_match_a (
    .src        (idex_q.rs),
    .src_used   (idex_q.rs_used),
    .exmem_rd   (exmem_q.rd),
    .exmem_we   (exmem_q.we),
    .exmem_load (exmem_q.load),
    .memwb_rd   (memwb_q.rd),
    .memwb_we   (memwb_q.we),
    .sel        (sel_a)
  );

  fwd_match #(.REG_AW(REG_AW)) u_match_b (
    .src        (idex_q.rt),
    .src_used   (idex_q.rt_used),
    .exmem_rd   (exmem_q.rd),
    .exmem_we   (exmem_q.we),
    .exmem_load (exmem_q.load),
    .memwb_rd   (memwb_q.rd),
    .memwb_we   (memwb_q.we),
    .sel        (sel_b)
  );

  assign bus.fa1   = sel_a[1];
  assign bus.fa2   = sel_a[0];
  assign bus.fb1   = sel_b[1];
  assign bus.fb2   = sel_b[0];
  assign bus.stall = stall_w;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: directed hazard programs followed by a
// random instruction stream, scored against a history-based reference model.
module tb_fwd_ctrl;

  typedef struct packed {
    logic [3:0] rs;
    logic [3:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic [3:0] rd;
    logic       we;
    logic       load;
  } ins_t;

  localparam ins_t NOP = '0;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_ctrl_if #(.REG_AW(4)) bus();

  fwd_ctrl #(.REG_AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------------------------------------------------------- model state
  // Instructions that have entered EX, newest first: [0]=EX, [1]=MEM, [2]=WB.
  ins_t       ex_hist[$];
  logic [4:0] exp_q[$];   // {fa1, fa2, fb1, fb2, stall}
  int         checks = 0;
  int         errors = 0;
  int         cycle  = 0;
  logic [4:0] mon_exp;
  logic [4:0] mon_act;
  ins_t       rnd_ins;
  bit         rnd_fl;
  bit         rnd_rst;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic ins_t mk(input int rd, input int rs, input int rt,
                              input bit rs_u, input bit rt_u,
                              input bit we, input bit ld);
    ins_t i;
    i.rd      = 4'(rd);
    i.rs      = 4'(rs);
    i.rt      = 4'(rt);
    i.rs_used = rs_u;
    i.rt_used = rt_u;
    i.we      = we;
    i.load    = ld;
    return i;
  endfunction

  // Source of the EX instruction vs. the two older instructions: the one just
  // ahead (unless it is a load, whose data is not ready) wins, then the next.
  function automatic logic [1:0] exp_fwd(input logic [3:0] src, input logic used);
    ins_t p1;
    ins_t p2;
    p1 = ex_hist[1];
    p2 = ex_hist[2];
    if (!used) return 2'b00;
    if (p1.we && !p1.load && p1.rd != 4'd0 && p1.rd == src) return 2'b10;
    if (p2.we && p2.rd != 4'd0 && p2.rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // ID instruction reads the register a load now in EX is about to write.
  function automatic logic exp_stall(input ins_t id);
    ins_t c;
    c = ex_hist[0];
    if (!(c.load && c.we && c.rd != 4'd0)) return 1'b0;
    return (id.rs_used && id.rs == c.rd) || (id.rt_used && id.rt == c.rd);
  endfunction

  function automatic void hist_clear();
    ex_hist = '{NOP, NOP, NOP};
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic drive(input ins_t i, input bit fl, input bit r);
    rst            = r;
    bus.id_rs      = i.rs;
    bus.id_rt      = i.rt;
    bus.id_rs_used = i.rs_used;
    bus.id_rt_used = i.rt_used;
    bus.id_rd      = i.rd;
    bus.id_we      = i.we;
    bus.id_load    = i.load;
    bus.flush      = fl;
  endtask

  // Present one instruction in ID; held and re-presented while it stalls.
  task automatic issue(input ins_t i, input bit fl, input bit r);
    logic st;
    do begin
      @(negedge clk);
      drive(i, fl, r);
      #1;
      st = exp_stall(i);
      exp_q.push_back({exp_fwd(ex_hist[0].rs, ex_hist[0].rs_used),
                       exp_fwd(ex_hist[0].rt, ex_hist[0].rt_used), st});
      @(posedge clk);
      if (r) begin
        hist_clear();
      end else begin
        ex_hist.push_front((st || fl) ? NOP : i);
        void'(ex_hist.pop_back());
      end
    end while (st && !fl && !r);
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) issue(NOP, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    #4;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {bus.fa1, bus.fa2, bus.fb1, bus.fb2, bus.stall};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL sel_stall cycle %0d: got fa=%b%b fb=%b%b stall=%b, expected fa=%b%b fb=%b%b stall=%b",
                 cycle, mon_act[4], mon_act[3], mon_act[2], mon_act[1], mon_act[0],
                 mon_exp[4], mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    hist_clear();
    drive(NOP, 1'b0, 1'b1);
    @(posedge clk);
    // Reset held: everything reads zero.
    issue(NOP, 1'b0, 1'b1);
    issue(NOP, 1'b0, 1'b1);
    nops(2);

    // ADD R3<-R1,R2 ; SUB R4<-R3,R5 : SUB in EX sees fa=10, fb=00.
    issue(mk(3, 1, 2, 1, 1, 1, 0), 1'b0, 1'b0);
    issue(mk(4, 3, 5, 1, 1, 1, 0), 1'b0, 1'b0);
    nops(3);

    // ADD R3 ; XOR R8<-R9,R10 ; AND R6<-R5,R3 : AND sees fb=01.
    issue(mk(3, 1, 2, 1, 1, 1, 0), 1'b0, 1'b0);
    issue(mk(8, 9, 10, 1, 1, 1, 0), 1'b0, 1'b0);
    issue(mk(6, 5, 3, 1, 1, 1, 0), 1'b0, 1'b0);
    nops(3);

    // ADD R3 ; ADD R3 ; SUB R7<-R3,R3 : fa=fb=10.
    issue(mk(3, 1, 2, 1, 1, 1, 0), 1'b0, 1'b0);
    issue(mk(3, 4, 5, 1, 1, 1, 0), 1'b0, 1'b0);
    issue(mk(7, 3, 3, 1, 1, 1, 0), 1'b0, 1'b0);
    nops(3);

    // LW R2 ; ADD R4<-R2,R1 : one stall cycle, then fa=01.
    issue(mk(2, 1, 0, 1, 0, 1, 1), 1'b0, 1'b0);
    issue(mk(4, 2, 1, 1, 1, 1, 0), 1'b0, 1'b0);
    nops(3);

    // ADD R0 ; OR R5<-R0,R0 : no forward from R0.
    issue(mk(0, 1, 2, 1, 1, 1, 0), 1'b0, 1'b0);
    issue(mk(5, 0, 0, 1, 1, 1, 0), 1'b0, 1'b0);
    nops(3);

    // LW R0 then reader of R0: no stall.
    issue(mk(0, 1, 0, 1, 0, 1, 1), 1'b0, 1'b0);
    issue(mk(5, 0, 0, 1, 1, 1, 0), 1'b0, 1'b0);
    nops(3);

    // LW R2 flushed in ID ; dependent ADD : no stall, no forward.
    issue(mk(2, 1, 0, 1, 0, 1, 1), 1'b1, 1'b0);
    issue(mk(4, 2, 1, 1, 1, 1, 0), 1'b0, 1'b0);
    nops(3);

    // LW R2 ; dependent ADD with flush during the stall cycle.
    issue(mk(2, 1, 0, 1, 0, 1, 1), 1'b0, 1'b0);
    issue(mk(4, 1, 2, 1, 1, 1, 0), 1'b1, 1'b0);
    nops(3);

    // LW R2 ; dependent ADD with reset during the stall cycle, then re-present.
    issue(mk(2, 1, 0, 1, 0, 1, 1), 1'b0, 1'b0);
    issue(mk(4, 2, 1, 1, 1, 1, 0), 1'b0, 1'b1);
    issue(mk(4, 2, 1, 1, 1, 1, 0), 1'b0, 1'b0);
    nops(3);

    // Random stream over a small register window to make hazards frequent.
    for (int n = 0; n < 400; n++) begin
      rnd_ins.rs      = 4'($urandom_range(0, 7));
      rnd_ins.rt      = 4'($urandom_range(0, 7));
      rnd_ins.rd      = 4'($urandom_range(0, 7));
      rnd_ins.rs_used = 1'($urandom_range(0, 3) != 0);
      rnd_ins.rt_used = 1'($urandom_range(0, 1));
      rnd_ins.load    = 1'($urandom_range(0, 9) < 3);
      rnd_ins.we      = 1'($urandom_range(0, 7) != 0);
      rnd_fl          = ($urandom_range(0, 11) == 0);
      rnd_rst         = ($urandom_range(0, 59) == 0);
      issue(rnd_ins, rnd_fl, rnd_rst);
    end
    nops(3);

    // Every pushed expectation must have been consumed.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
